// File: rtl/floppy_img_arbiter.sv
// ----------------------------------------------------------------------------
// floppy_img_arbiter: two-requester disk-image read arbiter with read watchdog.
// Optional FLOPPY_ARB_FIXED_PRIO_EN: requester 0 always wins contention.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module floppy_img_arbiter #(
  parameter int ADDR_W      = 22,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk8,
  input  logic              _reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        ack,
  output logic [7:0]        rdData,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [7:0]        memData,
  output logic              busy,
  output logic              timeoutPulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic [9:0]        timer, timer_nxt;
  logic [1:0]        ack_nxt;
  logic [7:0]        rd_data_nxt;
  logic              mem_req_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              busy_nxt;
  logic              timeout_nxt;
  logic              sel;

  // Arbitration choice for the current cycle's request vector.
  always_comb begin
    sel = 1'b0;
    if (req == 2'b10) begin
      sel = 1'b1;
    end else if (req == 2'b11) begin
`ifdef FLOPPY_ARB_FIXED_PRIO_EN
      sel = 1'b0 & last_grant;
`else
      sel = ~last_grant;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    ack_nxt        = ack;
    rd_data_nxt    = rdData;
    mem_req_nxt    = memReq;
    mem_addr_nxt   = memAddr;
    timeout_nxt    = timeoutPulse;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_nxt      = sel;
          last_grant_nxt = sel;
          mem_addr_nxt   = sel ? addr1 : addr0;
          mem_req_nxt    = 1'b1;
          timer_nxt      = 10'd0;
          state_nxt      = WAIT;
        end
      end
      WAIT: begin
        // A memAck landing on the watchdog cycle takes priority over the timeout.
        if (memAck) begin
          rd_data_nxt = memData;
          mem_req_nxt = 1'b0;
          ack_nxt     = grant ? 2'b10 : 2'b01;
          state_nxt   = DONE;
        end else if (timer == TIMER_LAST) begin
          rd_data_nxt = 8'hFF;
          mem_req_nxt = 1'b0;
          ack_nxt     = grant ? 2'b10 : 2'b01;
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          timer_nxt = timer + 10'd1;
        end
      end
      DONE: begin
        ack_nxt     = 2'b00;
        timeout_nxt = 1'b0;
        state_nxt   = GAP;
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk8 or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      timer        <= 10'd0;
      ack          <= 2'b00;
      rdData       <= 8'h00;
      memReq       <= 1'b0;
      memAddr      <= '0;
      busy         <= 1'b0;
      timeoutPulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      last_grant   <= last_grant_nxt;
      timer        <= timer_nxt;
      ack          <= ack_nxt;
      rdData       <= rd_data_nxt;
      memReq       <= mem_req_nxt;
      memAddr      <= mem_addr_nxt;
      busy         <= busy_nxt;
      timeoutPulse <= timeout_nxt;
    end
  end

endmodule

`default_nettype wire
